// File: rtl/vend_pkg.sv
// Purpose  : shared money codes and queue-state encoding for the coin front end and vending core.
// Latency  : n/a (declarations only).
// Backpress: n/a (declarations only).
// Contents : MONEY_* token codes, q_state_t queue occupancy, coin_evt_t per-slot event pair,
//            token_of() helper that maps a single slot event to its money code.
package vend_pkg;

    // Token codes on the money bus; the vending core decodes these same values.
    localparam logic [1:0] MONEY_NONE = 2'b00;
    localparam logic [1:0] MONEY_A    = 2'b01;
    localparam logic [1:0] MONEY_B    = 2'b10;

    // Occupancy of the two-entry token queue.
    typedef enum logic [1:0] {
        Q_EMPTY = 2'd0,
        Q_ONE   = 2'd1,
        Q_FULL  = 2'd2
    } q_state_t;

    // One cycle's worth of clean coin-insertion events, one bit per slot.
    typedef struct packed {
        logic a;
        logic b;
    } coin_evt_t;

    // Selects the money code for an event. Only meaningful when exactly one slot fired.
    function automatic logic [1:0] token_of(input coin_evt_t ev);
        return ev.a ? MONEY_A : MONEY_B;
    endfunction

endpackage

// File: rtl/coin_debounce.sv
// Purpose  : one coin slot: 2-flop synchroniser, stable-level debounce, 0->1 event detect.
// Latency  : raw high first sampled at edge T -> rise high after edge T+1+DEBOUNCE_CYCLES.
// Backpress: none; emits a single-cycle rise pulse and never stalls.
// Ports    : clk, reset (async, active high), raw (asynchronous bouncing sensor),
//            rise (one-cycle pulse when the debounced level goes 0->1).
module coin_debounce #(
    parameter int DEBOUNCE_CYCLES = 4    // must be >= 2
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic rise
);

    // The counter only has to hold 0 .. DEBOUNCE_CYCLES-1; the flip happens
    // instead of stepping to DEBOUNCE_CYCLES.
    localparam int              CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_1;
    logic          sync_2;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            level  <= 1'b0;
            cnt    <= '0;
            rise   <= 1'b0;
        end else begin
            // raw is asynchronous: sync_1 may go metastable, only sync_2 is used.
            sync_1 <= raw;
            sync_2 <= sync_1;
            rise   <= 1'b0;

            if (sync_2 == level) begin
                // Any return to the current level restarts the window, so a
                // bounce shorter than DEBOUNCE_CYCLES leaves no trace.
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // DEBOUNCE_CYCLES consecutive differing samples: accept the change.
                level <= sync_2;
                cnt   <= '0;
                rise  <= sync_2;   // only the 0->1 direction is an insertion
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/coin_acceptor.sv
// Purpose  : coin front end: debounces both slots, turns each insertion into one money token,
//            queues up to two tokens toward the vending core, flags jams and overflow.
// Latency  : raw first sampled high at edge T -> money_valid after edge T+2+DEBOUNCE_CYCLES (empty queue).
// Backpress: valid/ready on money; when the queue is full and not popping, new tokens are dropped
//            and the sticky overflow flag is raised.
// Ports    : clk, reset (async, active high); coin_a_raw / coin_b_raw raw slot sensors;
//            money / money_valid / money_ready token handshake; jam (1-cycle pulse);
//            overflow (sticky until reset); coin_count (saturating count of enqueued tokens).
module coin_acceptor #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int COUNT_W         = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               coin_a_raw,
    input  logic               coin_b_raw,
    output logic [1:0]         money,
    output logic               money_valid,
    input  logic               money_ready,
    output logic               jam,
    output logic               overflow,
    output logic [COUNT_W-1:0] coin_count
);

    import vend_pkg::*;

    coin_evt_t  ev;

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .clk   (clk),
        .reset (reset),
        .raw   (coin_a_raw),
        .rise  (ev.a)
    );

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .clk   (clk),
        .reset (reset),
        .raw   (coin_b_raw),
        .rise  (ev.b)
    );

    // ---------------------------------------------------------------
    // Two-entry token queue: head is what the core sees, tail is the
    // second-oldest token and only meaningful in Q_FULL.
    // ---------------------------------------------------------------
    q_state_t   q_state;
    q_state_t   q_state_nxt;
    logic [1:0] head;
    logic [1:0] head_nxt;
    logic [1:0] tail;
    logic [1:0] tail_nxt;
    logic [1:0] push_tok;
    logic       push;
    logic       pop;
    logic       accept;
    logic       drop;

    assign money_valid = (q_state != Q_EMPTY);
    assign money       = money_valid ? head : MONEY_NONE;

    always_comb begin
        // Both slots firing together is a jam: neither token is trusted.
        push     = ev.a ^ ev.b;
        push_tok = token_of(ev);
        pop      = money_valid && money_ready;
        // In Q_FULL a simultaneous pop frees the slot the push needs.
        accept   = push && ((q_state != Q_FULL) || pop);
        drop     = push && !accept;

        q_state_nxt = q_state;
        head_nxt    = head;
        tail_nxt    = tail;

        case (q_state)
            Q_EMPTY: begin
                if (push) begin
                    q_state_nxt = Q_ONE;
                    head_nxt    = push_tok;
                end
            end
            Q_ONE: begin
                case ({push, pop})
                    2'b11: head_nxt = push_tok;     // old head leaves, new one takes its place
                    2'b10: begin
                        tail_nxt    = push_tok;
                        q_state_nxt = Q_FULL;
                    end
                    2'b01:   q_state_nxt = Q_EMPTY;
                    default: ;
                endcase
            end
            Q_FULL: begin
                if (pop) begin
                    head_nxt = tail;
                    if (push) begin
                        tail_nxt = push_tok;
                    end else begin
                        q_state_nxt = Q_ONE;
                    end
                end
                // push without pop: the token is dropped and flagged below
            end
            default: q_state_nxt = Q_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_state <= Q_EMPTY;
            head    <= MONEY_NONE;
            tail    <= MONEY_NONE;
        end else begin
            q_state <= q_state_nxt;
            head    <= head_nxt;
            tail    <= tail_nxt;
        end
    end

    // ---------------------------------------------------------------
    // Status: jam pulse, sticky overflow, saturating accepted count.
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            jam        <= 1'b0;
            overflow   <= 1'b0;
            coin_count <= '0;
        end else begin
            jam <= ev.a & ev.b;
            if (drop) begin
                overflow <= 1'b1;
            end
            if (accept && (coin_count != {COUNT_W{1'b1}})) begin
                coin_count <= coin_count + COUNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_coin_acceptor.sv
module tb_coin_acceptor;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       coin_a_raw = 1'b0;
    logic       coin_b_raw = 1'b0;
    logic       money_ready = 1'b0;
    logic [1:0] money;
    logic       money_valid;
    logic       jam;
    logic       overflow;
    logic [7:0] coin_count;

    int total = 0;
    int bad   = 0;

    coin_acceptor #(.DEBOUNCE_CYCLES(DB), .COUNT_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .coin_a_raw  (coin_a_raw),
        .coin_b_raw  (coin_b_raw),
        .money       (money),
        .money_valid (money_valid),
        .money_ready (money_ready),
        .jam         (jam),
        .overflow    (overflow),
        .coin_count  (coin_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------
    // Behavioural model. Each slot keeps its raw-sample history (newest
    // first); the debounced view at an edge is the raw value from two
    // edges earlier. A level change is accepted when the last DB viewed
    // samples all disagree with the current level. An accepted 0->1 change
    // becomes an event that reaches the queue one edge later.
    // ---------------------------------------------------------------
    bit         ha[$];
    bit         hb[$];
    bit         lvl_a = 0, lvl_b = 0;
    bit         pend_a = 0, pend_b = 0;
    logic [1:0] mq[$];
    logic [7:0] m_count = 0;
    bit         m_ovf = 0;
    bit         m_jam = 0;

    function automatic bit settled(input bit h[$], input bit lvl);
        for (int k = 2; k < DB + 2; k++) begin
            bit s;
            s = (k < h.size()) ? h[k] : 1'b0;
            if (s == lvl) return 1'b0;
        end
        return 1'b1;
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                ha.delete(); hb.delete();
                lvl_a = 0; lvl_b = 0; pend_a = 0; pend_b = 0;
                mq.delete(); m_count = 0; m_ovf = 0; m_jam = 0;
            end else begin
                bit na, nb;
                // queue stage: events detected on the previous edge
                m_jam = pend_a && pend_b;
                if (mq.size() != 0 && money_ready) void'(mq.pop_front());
                if (pend_a != pend_b) begin
                    if (mq.size() < 2) begin
                        mq.push_back(pend_a ? 2'b01 : 2'b10);
                        if (m_count != 8'hFF) m_count++;
                    end else begin
                        m_ovf = 1;
                    end
                end
                // detection stage
                ha.push_front(coin_a_raw);
                hb.push_front(coin_b_raw);
                if (ha.size() > DB + 2) void'(ha.pop_back());
                if (hb.size() > DB + 2) void'(hb.pop_back());
                na = 0; nb = 0;
                if (settled(ha, lvl_a)) begin lvl_a = !lvl_a; na = lvl_a; end
                if (settled(hb, lvl_b)) begin lvl_b = !lvl_b; nb = lvl_b; end
                pend_a = na;
                pend_b = nb;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                check("cyc_valid",    money_valid, (mq.size() != 0));
                check("cyc_money",    money,       (mq.size() != 0) ? mq[0] : 2'b00);
                check("cyc_jam",      jam,         m_jam);
                check("cyc_overflow", overflow,    m_ovf);
                check("cyc_count",    coin_count,  m_count);
            end
        end
    end

    // Inputs change 1 time unit after a rising edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic coin_a();
        coin_a_raw = 1'b1; cyc(6);
        coin_a_raw = 1'b0; cyc(6);
    endtask

    task automatic coin_b();
        coin_b_raw = 1'b1; cyc(6);
        coin_b_raw = 1'b0; cyc(6);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int jam_cycles;
        int valid_cycles;

        // reset state
        #12;
        check("rst_valid", money_valid, 0);
        check("rst_money", money, 0);
        check("rst_count", coin_count, 0);
        #10 reset = 1'b0;
        cyc(1);

        // 1: A held 10 cycles with ready=1 -> one token, 6 cycles after first sample
        money_ready = 1'b1;
        coin_a_raw  = 1'b1;
        cyc(6);
        check("t1_not_yet", money_valid, 0);
        cyc(1);
        check("t1_valid", money_valid, 1);
        check("t1_money", money, 2'b01);
        check("t1_count", coin_count, 1);
        cyc(1);
        check("t1_popped", money_valid, 0);
        cyc(2);
        coin_a_raw = 1'b0;
        cyc(12);
        check("t1_one_token", coin_count, 1);

        // 2: B glitches of 1..3 cycles ignored, then a 6-cycle B is a token
        for (int len = 1; len <= 3; len++) begin
            coin_b_raw = 1'b1; cyc(len);
            coin_b_raw = 1'b0; cyc(6);
        end
        check("t2_glitch_count", coin_count, 1);
        money_ready = 1'b0;
        coin_b_raw  = 1'b1; cyc(6);
        coin_b_raw  = 1'b0; cyc(4);
        check("t2_valid", money_valid, 1);
        check("t2_money", money, 2'b10);
        check("t2_count", coin_count, 2);
        money_ready = 1'b1;
        cyc(1);
        check("t2_popped", money_valid, 0);

        // 3: ready=0, coins A,B,A -> two queued, third dropped with overflow
        money_ready = 1'b0;
        coin_a(); coin_b(); coin_a();
        check("t3_head", money, 2'b01);
        check("t3_overflow", overflow, 1);
        check("t3_count", coin_count, 4);
        money_ready = 1'b1;
        cyc(1);
        check("t3_second", money, 2'b10);
        check("t3_second_vld", money_valid, 1);
        cyc(1);
        check("t3_drained", money_valid, 0);
        check("t3_ovf_sticky", overflow, 1);

        // 4: A and B together -> single jam pulse, no token
        coin_a_raw = 1'b1; coin_b_raw = 1'b1;
        jam_cycles = 0; valid_cycles = 0;
        for (int i = 0; i < 16; i++) begin
            if (i == 6) begin coin_a_raw = 1'b0; coin_b_raw = 1'b0; end
            cyc(1);
            if (jam) jam_cycles++;
            if (money_valid) valid_cycles++;
        end
        check("t4_jam_len", jam_cycles, 1);
        check("t4_no_token", valid_cycles, 0);
        check("t4_count", coin_count, 4);

        // 5: queue ONE, push and pop on the same edge
        money_ready = 1'b0;
        coin_a();
        check("t5_one_head", money, 2'b01);
        coin_b_raw = 1'b1; cyc(6);
        coin_b_raw = 1'b0; money_ready = 1'b1;
        cyc(1);
        money_ready = 1'b0;
        check("t5_new_head", money, 2'b10);
        check("t5_valid", money_valid, 1);
        check("t5_count", coin_count, 6);
        cyc(1);
        money_ready = 1'b1;
        cyc(1);
        check("t5_was_one", money_valid, 0);

        // 6: reset with queue FULL and A mid-debounce
        money_ready = 1'b0;
        coin_a(); coin_b();
        check("t6_full_count", coin_count, 8);
        coin_a_raw = 1'b1;
        cyc(3);
        #2 reset = 1'b1;
        #1;
        check("t6_rst_valid", money_valid, 0);
        check("t6_rst_money", money, 0);
        check("t6_rst_jam", jam, 0);
        check("t6_rst_ovf", overflow, 0);
        check("t6_rst_count", coin_count, 0);
        @(posedge clk);
        #3 reset = 1'b0;
        cyc(6);
        check("t6_fresh_wait", money_valid, 0);
        cyc(1);
        check("t6_fresh_valid", money_valid, 1);
        check("t6_fresh_money", money, 2'b01);
        check("t6_fresh_count", coin_count, 1);
        coin_a_raw = 1'b0;
        cyc(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
